// File: rtl/des_pkg.sv
// Shared DES constants: half/expansion widths, S-box tables S1..S8 and the
// P permutation. Used by the pipelined f-function and the iterative round engine.
package des_pkg;

   localparam int DES_HALF_W = 32;
   localparam int DES_EXP_W  = 48;

   // SBOX[j][i]: box S(j+1), i = {row[1:0], col[3:0]} (row = {b5,b0}, col = b4..b1).
   localparam logic [3:0] SBOX [8][64] = '{
      '{ // S1
         4'd14, 4'd4,  4'd13, 4'd1,  4'd2,  4'd15, 4'd11, 4'd8,  4'd3,  4'd10, 4'd6,  4'd12, 4'd5,  4'd9,  4'd0,  4'd7,
         4'd0,  4'd15, 4'd7,  4'd4,  4'd14, 4'd2,  4'd13, 4'd1,  4'd10, 4'd6,  4'd12, 4'd11, 4'd9,  4'd5,  4'd3,  4'd8,
         4'd4,  4'd1,  4'd14, 4'd8,  4'd13, 4'd6,  4'd2,  4'd11, 4'd15, 4'd12, 4'd9,  4'd7,  4'd3,  4'd10, 4'd5,  4'd0,
         4'd15, 4'd12, 4'd8,  4'd2,  4'd4,  4'd9,  4'd1,  4'd7,  4'd5,  4'd11, 4'd3,  4'd14, 4'd10, 4'd0,  4'd6,  4'd13},
      '{ // S2
         4'd15, 4'd1,  4'd8,  4'd14, 4'd6,  4'd11, 4'd3,  4'd4,  4'd9,  4'd7,  4'd2,  4'd13, 4'd12, 4'd0,  4'd5,  4'd10,
         4'd3,  4'd13, 4'd4,  4'd7,  4'd15, 4'd2,  4'd8,  4'd14, 4'd12, 4'd0,  4'd1,  4'd10, 4'd6,  4'd9,  4'd11, 4'd5,
         4'd0,  4'd14, 4'd7,  4'd11, 4'd10, 4'd4,  4'd13, 4'd1,  4'd5,  4'd8,  4'd12, 4'd6,  4'd9,  4'd3,  4'd2,  4'd15,
         4'd13, 4'd8,  4'd10, 4'd1,  4'd3,  4'd15, 4'd4,  4'd2,  4'd11, 4'd6,  4'd7,  4'd12, 4'd0,  4'd5,  4'd14, 4'd9},
      '{ // S3
         4'd10, 4'd0,  4'd9,  4'd14, 4'd6,  4'd3,  4'd15, 4'd5,  4'd1,  4'd13, 4'd12, 4'd7,  4'd11, 4'd4,  4'd2,  4'd8,
         4'd13, 4'd7,  4'd0,  4'd9,  4'd3,  4'd4,  4'd6,  4'd10, 4'd2,  4'd8,  4'd5,  4'd14, 4'd12, 4'd11, 4'd15, 4'd1,
         4'd13, 4'd6,  4'd4,  4'd9,  4'd8,  4'd15, 4'd3,  4'd0,  4'd11, 4'd1,  4'd2,  4'd12, 4'd5,  4'd10, 4'd14, 4'd7,
         4'd1,  4'd10, 4'd13, 4'd0,  4'd6,  4'd9,  4'd8,  4'd7,  4'd4,  4'd15, 4'd14, 4'd3,  4'd11, 4'd5,  4'd2,  4'd12},
      '{ // S4
         4'd7,  4'd13, 4'd14, 4'd3,  4'd0,  4'd6,  4'd9,  4'd10, 4'd1,  4'd2,  4'd8,  4'd5,  4'd11, 4'd12, 4'd4,  4'd15,
         4'd13, 4'd8,  4'd11, 4'd5,  4'd6,  4'd15, 4'd0,  4'd3,  4'd4,  4'd7,  4'd2,  4'd12, 4'd1,  4'd10, 4'd14, 4'd9,
         4'd10, 4'd6,  4'd9,  4'd0,  4'd12, 4'd11, 4'd7,  4'd13, 4'd15, 4'd1,  4'd3,  4'd14, 4'd5,  4'd2,  4'd8,  4'd4,
         4'd3,  4'd15, 4'd0,  4'd6,  4'd10, 4'd1,  4'd13, 4'd8,  4'd9,  4'd4,  4'd5,  4'd11, 4'd12, 4'd7,  4'd2,  4'd14},
      '{ // S5
         4'd2,  4'd12, 4'd4,  4'd1,  4'd7,  4'd10, 4'd11, 4'd6,  4'd8,  4'd5,  4'd3,  4'd15, 4'd13, 4'd0,  4'd14, 4'd9,
         4'd14, 4'd11, 4'd2,  4'd12, 4'd4,  4'd7,  4'd13, 4'd1,  4'd5,  4'd0,  4'd15, 4'd10, 4'd3,  4'd9,  4'd8,  4'd6,
         4'd4,  4'd2,  4'd1,  4'd11, 4'd10, 4'd13, 4'd7,  4'd8,  4'd15, 4'd9,  4'd12, 4'd5,  4'd6,  4'd3,  4'd0,  4'd14,
         4'd11, 4'd8,  4'd12, 4'd7,  4'd1,  4'd14, 4'd2,  4'd13, 4'd6,  4'd15, 4'd0,  4'd9,  4'd10, 4'd4,  4'd5,  4'd3},
      '{ // S6
         4'd12, 4'd1,  4'd10, 4'd15, 4'd9,  4'd2,  4'd6,  4'd8,  4'd0,  4'd13, 4'd3,  4'd4,  4'd14, 4'd7,  4'd5,  4'd11,
         4'd10, 4'd15, 4'd4,  4'd2,  4'd7,  4'd12, 4'd9,  4'd5,  4'd6,  4'd1,  4'd13, 4'd14, 4'd0,  4'd11, 4'd3,  4'd8,
         4'd9,  4'd14, 4'd15, 4'd5,  4'd2,  4'd8,  4'd12, 4'd3,  4'd7,  4'd0,  4'd4,  4'd10, 4'd1,  4'd13, 4'd11, 4'd6,
         4'd4,  4'd3,  4'd2,  4'd12, 4'd9,  4'd5,  4'd15, 4'd10, 4'd11, 4'd14, 4'd1,  4'd7,  4'd6,  4'd0,  4'd8,  4'd13},
      '{ // S7
         4'd4,  4'd11, 4'd2,  4'd14, 4'd15, 4'd0,  4'd8,  4'd13, 4'd3,  4'd12, 4'd9,  4'd7,  4'd5,  4'd10, 4'd6,  4'd1,
         4'd13, 4'd0,  4'd11, 4'd7,  4'd4,  4'd9,  4'd1,  4'd10, 4'd14, 4'd3,  4'd5,  4'd12, 4'd2,  4'd15, 4'd8,  4'd6,
         4'd1,  4'd4,  4'd11, 4'd13, 4'd12, 4'd3,  4'd7,  4'd14, 4'd10, 4'd15, 4'd6,  4'd8,  4'd0,  4'd5,  4'd9,  4'd2,
         4'd6,  4'd11, 4'd13, 4'd8,  4'd1,  4'd4,  4'd10, 4'd7,  4'd9,  4'd5,  4'd0,  4'd15, 4'd14, 4'd2,  4'd3,  4'd12},
      '{ // S8
         4'd13, 4'd2,  4'd8,  4'd4,  4'd6,  4'd15, 4'd11, 4'd1,  4'd10, 4'd9,  4'd3,  4'd14, 4'd5,  4'd0,  4'd12, 4'd7,
         4'd1,  4'd15, 4'd13, 4'd8,  4'd10, 4'd3,  4'd7,  4'd4,  4'd12, 4'd5,  4'd6,  4'd11, 4'd0,  4'd14, 4'd9,  4'd2,
         4'd7,  4'd11, 4'd4,  4'd1,  4'd9,  4'd12, 4'd14, 4'd2,  4'd0,  4'd6,  4'd10, 4'd13, 4'd15, 4'd3,  4'd5,  4'd8,
         4'd2,  4'd1,  4'd14, 4'd7,  4'd4,  4'd10, 4'd8,  4'd13, 4'd15, 4'd12, 4'd9,  4'd0,  4'd3,  4'd5,  4'd6,  4'd11}
   };

   // P_TAB[k-1] = 1-based source bit (counted from MSB) for output bit k.
   localparam int P_TAB [32] = '{
      16, 7,  20, 21, 29, 12, 28, 17,
      1,  15, 23, 26, 5,  18, 31, 10,
      2,  8,  24, 14, 32, 27, 3,  9,
      19, 13, 30, 6,  22, 11, 4,  25
   };

   // Vector index (LSB = 0) of the S-output bit feeding P output position k (0-based from MSB).
   function automatic logic [4:0] p_src_idx(input int k);
      return 5'(DES_HALF_W - P_TAB[k]);
   endfunction

endpackage

// File: rtl/des_sbox_p.sv
// Combinational DES S-box substitution (48 -> 32) followed by the P permutation.
module des_sbox_p
   import des_pkg::*;
(
   input  logic [DES_EXP_W-1:0]  x_i,
   output logic [DES_HALF_W-1:0] f_o
);

   logic [DES_HALF_W-1:0] s;

   // Eight 6->4 lookups; row = outer bits, column = inner four bits.
   always_comb begin
      s = '0;
      for (int j = 0; j < 8; j++) begin
         logic [5:0] b;
         b = x_i[47-6*j -: 6];
         s[31-4*j -: 4] = SBOX[j][{b[5], b[0], b[4:1]}];
      end
   end

   // Fixed bit permutation of the concatenated S-box outputs.
   always_comb begin
      f_o = '0;
      for (int k = 0; k < DES_HALF_W; k++) begin
         f_o[31-k] = s[p_src_idx(k)];
      end
   end

endmodule

// File: rtl/des_f_pipe.sv
// Two-stage pipelined DES f-function: stage 1 registers E(R) ^ K,
// stage 2 registers P(S(.)). Valid/ready handshake with a bubble-free ready chain.
module des_f_pipe
   import des_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DES_EXP_W-1:0]  in_expanded_R,
   input  logic [DES_EXP_W-1:0]  in_subkey,
   input  logic [TAG_W-1:0]      in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DES_HALF_W-1:0] out_f,
   output logic [TAG_W-1:0]      out_tag
);

   logic                  s1_valid_q, s1_valid_d;
   logic [DES_EXP_W-1:0]  s1_x_q,     s1_x_d;
   logic [TAG_W-1:0]      s1_tag_q,   s1_tag_d;
   logic                  out_valid_q, out_valid_d;
   logic [DES_HALF_W-1:0] out_f_q,    out_f_d;
   logic [TAG_W-1:0]      out_tag_q,  out_tag_d;
   logic                  s2_ready;
   logic [DES_HALF_W-1:0] sbox_f;

   des_sbox_p u_sbox_p (
      .x_i (s1_x_q),
      .f_o (sbox_f)
   );

   // Ready chain: a stage may load whenever it is empty or its contents move on this edge.
   always_comb begin
      s2_ready = !out_valid_q || out_ready;
      in_ready = !s1_valid_q || s2_ready;
   end

   // Stage 1 next state: valid follows in_valid when loading, payload only on a real transfer.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_x_d     = s1_x_q;
      s1_tag_d   = s1_tag_q;
      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_x_d   = in_expanded_R ^ in_subkey;
            s1_tag_d = in_tag;
         end
      end
   end

   // Stage 2 next state: payload only changes when a valid word moves forward.
   always_comb begin
      out_valid_d = out_valid_q;
      out_f_d     = out_f_q;
      out_tag_d   = out_tag_q;
      if (s2_ready) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_f_d   = sbox_f;
            out_tag_d = s1_tag_q;
         end
      end
   end

   // Pipeline registers; reset drops anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_x_q      <= '0;
         s1_tag_q    <= '0;
         out_valid_q <= 1'b0;
         out_f_q     <= '0;
         out_tag_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_x_q      <= s1_x_d;
         s1_tag_q    <= s1_tag_d;
         out_valid_q <= out_valid_d;
         out_f_q     <= out_f_d;
         out_tag_q   <= out_tag_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_f     = out_f_q;
   assign out_tag   = out_tag_q;

endmodule
